button_stepper: RTL
===================

BUTTON_STEPPER -- requirements
Module: button_stepper

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 20_000, giving the stable-level cycles required to accept a press or a release.
REQ-002 The module SHALL have parameter REPEAT_CYCLES, default 1_000_000, giving the hold cycles between auto-repeat steps.
REQ-003 Port Clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port E_Button, input, 1 bit: raw asynchronous button, 0 = pressed.
REQ-006 Port Ctrl, input, 1 bit: raw asynchronous direction switch, 1 = up, 0 = down.
REQ-007 Port Step, output, 1 bit: single-cycle pulse, one per accepted step event.
REQ-008 Port Up, output, 1 bit: direction, valid in every cycle where Step = 1.
REQ-009 Port Pressed, output, 1 bit: debounced button-held level.

Function
REQ-010 E_Button and Ctrl SHALL each pass through a two-flop synchronizer before any use; sb denotes synchronized E_Button and sc synchronized Ctrl.
REQ-011 The FSM SHALL have states IDLE, PRESS_DB, HELD and RELEASE_DB, plus one counter of width $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1).
REQ-012 In IDLE with sb = 0, the FSM SHALL go to PRESS_DB and clear the counter.
REQ-013 In PRESS_DB with sb = 1, the FSM SHALL return to IDLE with no Step.
REQ-014 In PRESS_DB with sb = 0 and counter = DEBOUNCE_CYCLES-1, the FSM SHALL go to HELD, pulse Step, load Up from sc and clear the counter.
REQ-015 The first Step SHALL assert exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples E_Button low, provided E_Button is held low.
REQ-016 In HELD with sb = 0, the counter SHALL increment; at REPEAT_CYCLES-1 it SHALL pulse Step, load Up from sc and clear (auto-repeat, see REQ-027).
REQ-017 In HELD with sb = 1, the FSM SHALL go to RELEASE_DB and clear the counter.
REQ-018 In RELEASE_DB with sb = 0, the FSM SHALL return to HELD, clear the counter and produce no Step.
REQ-019 In RELEASE_DB with sb = 1 and counter = DEBOUNCE_CYCLES-1, the FSM SHALL go to IDLE.
REQ-020 Pressed SHALL be 1 exactly in HELD and RELEASE_DB.
REQ-021 Up SHALL change only in cycles where Step = 1; a Ctrl change during a hold therefore takes effect at the next step.
REQ-022 Step SHALL never be high in two consecutive cycles.
REQ-023 Elaboration SHALL fail unless DEBOUNCE_CYCLES >= 1 and REPEAT_CYCLES > DEBOUNCE_CYCLES.

Reset
REQ-024 On Rst_n = 0, the module SHALL immediately force Step = 0, Up = 0, Pressed = 0, state = IDLE and counter = 0, and set both synchronizer chains to 1 (released / up).
REQ-025 After Rst_n rises with the button still low, the press SHALL be re-debounced from IDLE, with no carried-over state.
REQ-026 Reset asserted during any state SHALL discard a pending Step.

Configuration
REQ-027 Macro BUTTON_STEPPER_AUTOREPEAT_EN SHALL control auto-repeat.
- Defined: HELD SHALL repeat Step every REPEAT_CYCLES cycles as in REQ-016.
- Undefined: HELD SHALL only wait for release, giving exactly one Step per accepted press; REPEAT_CYCLES is then unused but still checked.

Structure
REQ-028 Package button_stepper_pkg SHALL hold the state enum typedef and the default DEBOUNCE_CYCLES and REPEAT_CYCLES constants.
REQ-029 Each synchronizer SHALL be an instance of sub-module sync2 (1-bit, two flops, asynchronous active-low reset, reset value parameterized).

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10; edge 0 = first edge sampling E_Button low)
REQ-030 Clean press: Ctrl=1, E_Button low for 8 cycles then high -> one Step at edge 6, Up=1; Pressed 1 from edge 6 until 4 stable-high cycles after release.
REQ-031 Glitch rejection: E_Button low for 3 cycles -> no Step, Pressed stays 0, FSM back in IDLE.
REQ-032 Long hold of 30 cycles:
- With BUTTON_STEPPER_AUTOREPEAT_EN: Steps at edges 6, 16 and 26.
- Without the macro: a Step at edge 6 only.
REQ-033 Release bounce: during a hold, E_Button high for 2 cycles then low again -> no extra Step, Pressed stays 1, and the repeat counter restarts.
REQ-034 Direction change: Ctrl=0 at press, switched to 1 at edge 10, with auto-repeat -> Up=0 at edge 6 and Up=1 at edge 16.
REQ-035 Reset mid-hold: Rst_n low for 1 cycle at edge 12 with the button still low -> Step, Up and Pressed 0 immediately; after release of Rst_n, Step again DEBOUNCE_CYCLES+2 edges later.

Source files
------------

// File: rtl/button_stepper_pkg.sv
// Shared types and defaults for the button_stepper block: FSM state
// encoding, default timing constants and the counter-width helper.
package button_stepper_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 20_000;
    localparam int DEFAULT_REPEAT_CYCLES   = 1_000_000;

    // Width needed to hold any count up to the larger of the two limits.
    function automatic int count_width(input int debounce, input int repeat_len);
        return $clog2(((debounce > repeat_len) ? debounce : repeat_len) + 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit. Both flops reset
// to RESET_VALUE so the synchronized output starts at a known level.
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so both flops
        // sample their old values on the same edge and form a real 2-stage chain.
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_stepper.sv
// Debounced push-button stepper. Synchronizes the raw button and direction
// switch, debounces press and release, and emits a one-cycle Step pulse
// with a direction (Up) for each accepted press.
// Optional feature: define BUTTON_STEPPER_AUTOREPEAT_EN to repeat Step every
// REPEAT_CYCLES cycles while the button is held; without it a press gives
// exactly one Step.
module button_stepper
    import button_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic E_Button,
    input  logic Ctrl,
    output logic Step,
    output logic Up,
    output logic Pressed
);

    localparam int CNT_W = count_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Reject parameter sets where debounce is empty or repeat would not
    // outlast the debounce window (checked even when repeat is compiled out).
    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("button_stepper: need DEBOUNCE_CYCLES >= 1 and REPEAT_CYCLES > DEBOUNCE_CYCLES");
    end

    logic             sb;     // synchronized button, 0 = pressed
    logic             sc;     // synchronized direction, 1 = up
    state_e           state;
    logic [CNT_W-1:0] count;

    // Reset to 1 so a power-up reads as "released" and "up".
    sync2 #(.RESET_VALUE(1'b1)) u_sync_button (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (E_Button),
        .q     (sb)
    );

    sync2 #(.RESET_VALUE(1'b1)) u_sync_ctrl (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (Ctrl),
        .q     (sc)
    );

    // Debounce FSM with registered Step/Up/Pressed; one counter serves both
    // the debounce windows and the auto-repeat interval.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            count   <= '0;
            Step    <= 1'b0;
            Up      <= 1'b0;
            Pressed <= 1'b0;
        end else begin
            Step <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!sb) begin
                        state <= PRESS_DB;
                        count <= '0;
                    end
                end

                PRESS_DB: begin
                    if (sb) begin
                        // Bounce during press: drop it silently.
                        state <= IDLE;
                        count <= '0;
                    end else if (count == DB_LAST) begin
                        state   <= HELD;
                        count   <= '0;
                        Step    <= 1'b1;
                        Up      <= sc;
                        Pressed <= 1'b1;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end

                HELD: begin
                    if (sb) begin
                        state <= RELEASE_DB;
                        count <= '0;
                    end
`ifdef BUTTON_STEPPER_AUTOREPEAT_EN
                    else if (count == RPT_LAST) begin
                        count <= '0;
                        Step  <= 1'b1;
                        Up    <= sc;
                    end else begin
                        count <= count + CNT_ONE;
                    end
`endif
                end

                RELEASE_DB: begin
                    if (!sb) begin
                        // Release bounce: back to holding, repeat interval restarts.
                        state <= HELD;
                        count <= '0;
                    end else if (count == DB_LAST) begin
                        state   <= IDLE;
                        count   <= '0;
                        Pressed <= 1'b0;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
